// File: rtl/acc_drain_ctrl.sv
// acc_drain_ctrl: walks accumulator rows and streams them out on valid/ready.
// Define ACC_DRAIN_RELU_EN to zero negative lanes as rows enter the FIFO.
module acc_drain_ctrl #(
  parameter int DEPTH          = 8,
  parameter int ARRAY_M        = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int IDX_WIDTH      = $clog2(DEPTH),
  parameter int DATA_SET_WIDTH = ARRAY_M*DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [IDX_WIDTH:0]             num_rows,
  output logic                           busy,
  output logic                           done,
  output logic [IDX_WIDTH*ARRAY_M-1:0]   acc_idx_set,
  output logic [ARRAY_M-1:0]             acc_enable_set,
  output logic                           acc_drain,
  input  logic [DATA_SET_WIDTH-1:0]      acc_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_SET_WIDTH-1:0]      out_data,
  output logic [IDX_WIDTH-1:0]           out_idx,
  output logic                           out_last
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FLUSH
  } state_e;

  localparam logic [IDX_WIDTH:0] DEPTH_C = (IDX_WIDTH+1)'(DEPTH);
  localparam logic [IDX_WIDTH:0] ONE_C   = (IDX_WIDTH+1)'(1);

  state_e state_q, state_d;

  logic [IDX_WIDTH-1:0] row_q, row_d;
  logic [IDX_WIDTH:0]   nrows_q, nrows_d;
  logic                 zdone_q, zdone_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 wr_ptr_q, rd_ptr_q;

  logic [DATA_SET_WIDTH-1:0] fdata_q [2];
  logic [IDX_WIDTH-1:0]      fidx_q  [2];
  logic [1:0]                flast_q;

  logic [IDX_WIDTH:0]        clamp;
  logic                      start_ok;
  logic                      valid_w;
  logic                      pop;
  logic                      rd;
  logic                      last_row;
  logic [DATA_SET_WIDTH-1:0] wdata;

  assign clamp    = (num_rows > DEPTH_C) ? DEPTH_C : num_rows;
  assign start_ok = start && (state_q == IDLE) && (clamp != '0);
  assign valid_w  = (cnt_q != 2'd0);
  assign pop      = valid_w && out_ready;
  assign last_row = ({1'b0, row_q} == (nrows_q - ONE_C));

  // A full FIFO may still accept a row when the head leaves this cycle.
  assign rd = (state_q == ISSUE) && ((cnt_q != 2'd2) || pop);

  always_comb begin
    wdata = acc_out;
`ifdef ACC_DRAIN_RELU_EN
    for (int m = 0; m < ARRAY_M; m++) begin
      if (acc_out[m*DATA_WIDTH + DATA_WIDTH-1]) begin
        wdata[m*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = ISSUE;
      ISSUE:   if (rd && last_row) state_d = FLUSH;
      FLUSH:   if (cnt_q == 2'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q != IDLE);
    done           = ((state_q == FLUSH) && (cnt_q == 2'd0)) || zdone_q;
    acc_drain      = rd;
    acc_enable_set = rd ? '1 : '0;
    acc_idx_set    = rd ? {ARRAY_M{row_q}} : '0;
    out_valid      = valid_w;
    out_data       = valid_w ? fdata_q[rd_ptr_q] : '0;
    out_idx        = valid_w ? fidx_q[rd_ptr_q] : '0;
    out_last       = valid_w && flast_q[rd_ptr_q];
  end

  always_comb begin
    row_d   = row_q;
    nrows_d = nrows_q;
    zdone_d = start && (state_q == IDLE) && (clamp == '0);
    if (start_ok) begin
      row_d   = '0;
      nrows_d = clamp;
    end else if (rd && !last_row) begin
      row_d = row_q + IDX_WIDTH'(1);
    end
    unique case ({rd, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q    <= '0;
      nrows_q  <= '0;
      zdone_q  <= 1'b0;
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      flast_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        fdata_q[i] <= '0;
        fidx_q[i]  <= '0;
      end
    end else begin
      row_q   <= row_d;
      nrows_q <= nrows_d;
      zdone_q <= zdone_d;
      cnt_q   <= cnt_d;
      if (rd) begin
        fdata_q[wr_ptr_q] <= wdata;
        fidx_q[wr_ptr_q]  <= row_q;
        flast_q[wr_ptr_q] <= last_row;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_acc_drain_ctrl.sv
// tb_acc_drain_ctrl: transaction model of the drain plus directed scenarios.
// Model predicts beats, done timing and read legality; literals pin the model.
module tb_acc_drain_ctrl;

  localparam int DEPTH = 8;
  localparam int M     = 8;
  localparam int DW    = 32;
  localparam int IW    = 3;
  localparam int SW    = M*DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [IW:0]   num_rows = '0;
  logic          out_ready = 1'b0;
  logic          busy, done, acc_drain, out_valid, out_last;
  logic [IW*M-1:0] acc_idx_set;
  logic [M-1:0]  acc_enable_set;
  logic [SW-1:0] acc_out, out_data;
  logic [IW-1:0] out_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pat = 0;
  int rmode = 0;

  acc_drain_ctrl #(
    .DEPTH(DEPTH), .ARRAY_M(M), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .busy(busy), .done(done), .acc_idx_set(acc_idx_set),
    .acc_enable_set(acc_enable_set), .acc_drain(acc_drain),
    .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] lane_val(int p, int k, int m);
    if (p == 0) return DW'(k*16 + m);
    return (m % 2 == 0) ? 32'hFFFF_FFF0 : 32'h0000_0010;
  endfunction

  function automatic logic [SW-1:0] row_val(int p, int k);
    logic [SW-1:0] r;
    for (int m = 0; m < M; m++) r[m*DW +: DW] = lane_val(p, k, m);
    return r;
  endfunction

  function automatic logic [SW-1:0] exp_row(int p, int k);
    logic [SW-1:0] r;
    r = row_val(p, k);
`ifdef ACC_DRAIN_RELU_EN
    for (int m = 0; m < M; m++)
      if (r[m*DW + DW-1]) r[m*DW +: DW] = '0;
`endif
    return r;
  endfunction

  // Accumulator RAM stand-in: row visible only during a read cycle.
  always_comb begin
    acc_out = {8{32'hDEAD_BEEF}};
    if (acc_drain) acc_out = row_val(pat, int'(acc_idx_set[IW-1:0]));
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
  end

  task automatic chk(string nm, logic [SW-1:0] act, logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkb(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [IW-1:0] idx;
    logic [SW-1:0] data;
    logic          last;
  } beat_t;

  beat_t expq[$];
  beat_t e;
  bit m_busy = 0;
  bit done_due = 0;
  bit done_nxt;
  bit idle_now;
  bit pop;
  int occ = 0;
  int nrd = 0;
  int rd_left = 0;
  int n;
  bit prev_stall = 0;
  logic [SW-1:0] pdata;
  logic [IW-1:0] pidx;
  logic plast;
  int acc_cyc = 0, done_cyc = 0, fv_cyc = -1;
  int beats = 0, max_idx = 0, done_cnt = 0;
  logic [SW-1:0] got [8];

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_ctl", SW'({busy, done, acc_drain, acc_enable_set, acc_idx_set,
                          out_valid, out_last, out_idx}), '0);
      chk("rst_data", out_data, '0);
      expq.delete();
      m_busy = 0; done_due = 0; occ = 0; prev_stall = 0; rd_left = 0;
    end else begin
      pop = out_valid && out_ready;
      chkb("done", done, done_due);
      chkb("busy", busy, m_busy);
      if (done) begin done_cyc = cyc; done_cnt++; end
      if (acc_drain) begin
        chkb("rd_space", (occ < 2) || pop, 1'b1);
        chkb("rd_allowed", rd_left > 0, 1'b1);
        chk("rd_idx", SW'(acc_idx_set), SW'({M{IW'(nrd)}}));
        chk("rd_en", SW'(acc_enable_set), SW'({M{1'b1}}));
        nrd++;
        rd_left--;
      end else begin
        chk("idle_rd", SW'({acc_enable_set, acc_idx_set}), '0);
      end
      chkb("valid", out_valid, occ != 0);
      if (prev_stall) begin
        chkb("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, pdata);
        chk("stall_idx", SW'(out_idx), SW'(pidx));
        chkb("stall_last", out_last, plast);
      end
      if (out_valid && fv_cyc < 0) fv_cyc = cyc;
      done_nxt = 0;
      if (pop) begin
        if (expq.size() == 0) begin
          chkb("unexpected_beat", out_valid, 1'b0);
        end else begin
          e = expq.pop_front();
          chk("beat_idx", SW'(out_idx), SW'(e.idx));
          chk("beat_data", out_data, e.data);
          chkb("beat_last", out_last, e.last);
          got[out_idx] = out_data;
          beats++;
          if (int'(out_idx) > max_idx) max_idx = int'(out_idx);
          if (e.last) done_nxt = 1;
        end
      end
      prev_stall = out_valid && !out_ready;
      pdata = out_data; pidx = out_idx; plast = out_last;
      occ = occ + int'(acc_drain) - int'(pop);
      idle_now = !m_busy;
      if (done_due) m_busy = 0;
      done_due = done_nxt;
      if (start && idle_now) begin
        acc_cyc = cyc; fv_cyc = -1; beats = 0; max_idx = 0;
        done_cnt = 0; nrd = 0;
        n = (int'(num_rows) > DEPTH) ? DEPTH : int'(num_rows);
        rd_left = n;
        if (n == 0) begin
          done_due = 1;
        end else begin
          m_busy = 1;
          for (int k = 0; k < n; k++)
            expq.push_back('{idx: IW'(k), data: exp_row(pat, k), last: (k == n-1)});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(int rows);
    start = 1'b1;
    num_rows = (IW+1)'(rows);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    while ((m_busy || done_due || expq.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    chkb("drain_complete", m_busy || done_due || (expq.size() != 0), 1'b0);
    tick();
  endtask

  initial begin
    int k;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();

    // Full drain, sink always ready
    pulse_start(8);
    wait_idle(40);
    chk_int("t1_done_lat", done_cyc - acc_cyc, 10);
    chk_int("t1_valid_lat", fv_cyc - acc_cyc, 2);
    chk_int("t1_beats", beats, 8);
    chk_int("t1_row3_lane2", int'(got[3][95:64]), 32'h32);
    chk_int("t1_row7_lane7", int'(got[7][255:224]), 32'h77);

    // Back-pressured drain
    rmode = 1;
    tick();
    pulse_start(4);
    wait_idle(60);
    chk_int("t2_beats", beats, 4);
    chk_int("t2_max_idx", max_idx, 3);
    chk_int("t2_row2_lane5", int'(got[2][191:160]), 32'h25);
    rmode = 0;
    tick();

    // Empty drain
    pulse_start(0);
    wait_idle(10);
    chk_int("t3_done_lat", done_cyc - acc_cyc, 1);
    chk_int("t3_reads", nrd, 0);
    chk_int("t3_beats", beats, 0);

    // Over-range row count clamps to DEPTH
    pulse_start(12);
    wait_idle(40);
    chk_int("t4_beats", beats, 8);
    chk_int("t4_max_idx", max_idx, 7);
    chk_int("t4_reads", nrd, 8);

    // Start while busy is ignored; negative/positive lane pattern
    pat = 1;
    pulse_start(5);
    tick();
    pulse_start(2);
    wait_idle(40);
    chk_int("t5_beats", beats, 5);
    chk_int("t5_dones", done_cnt, 1);
`ifdef ACC_DRAIN_RELU_EN
    chk_int("t5_neg_lane", int'(got[0][31:0]), 0);
`else
    chk_int("t5_neg_lane", int'(got[0][31:0]), 32'hFFFF_FFF0);
`endif
    chk_int("t5_pos_lane", int'(got[0][63:32]), 32'h10);
    pat = 0;
    tick();

    // Reset mid-drain, then a fresh drain from row 0
    pulse_start(8);
    k = 0;
    while (beats < 3 && k < 20) begin
      tick();
      k++;
    end
    chk_int("t6_reach_beat3", beats, 3);
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    pulse_start(8);
    wait_idle(40);
    chk_int("t6_beats", beats, 8);
    chk_int("t6_row0_lane1", int'(got[0][63:32]), 1);
    chk_int("t6_done_lat", done_cyc - acc_cyc, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
